// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } mem_arb_state_t;

    // Command presented to physical memory; held for a whole transaction.
    typedef struct packed {
        logic           rd;
        logic           wr;
        rv32i_word      addr;
        rv32i_word      wdata;
        rv32i_mem_wmask be;
    } mem_cmd_t;

    localparam rv32i_mem_wmask BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Next-grant selection for the memory arbiter. D wins from IDLE; on
// completion of a D transaction, FAIR hands the bus to a waiting I port.
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  mem_arb_state_t state_i,
    input  logic           i_req_i,
    input  logic           d_req_i,
    input  logic           mem_resp_i,
    output mem_arb_state_t next_o,
    output logic           grant_o
);

    // Next state and a strobe marking the edge a new transaction is granted.
    always_comb begin
        next_o  = state_i;
        grant_o = 1'b0;
        case (state_i)
            IDLE: begin
                if (d_req_i)      next_o = SERVE_D;
                else if (i_req_i) next_o = SERVE_I;
                else              next_o = IDLE;
            end
            SERVE_D: begin
                if (mem_resp_i) begin
                    if (FAIR && i_req_i) next_o = SERVE_I;
                    else if (d_req_i)    next_o = SERVE_D;
                    else                 next_o = IDLE;
                end
            end
            SERVE_I: begin
                if (mem_resp_i) begin
                    if (d_req_i)      next_o = SERVE_D;
                    else if (i_req_i) next_o = SERVE_I;
                    else              next_o = IDLE;
                end
            end
            default: next_o = IDLE;
        endcase
        // Grant only when the bus is free: from IDLE, or as the current
        // transaction completes (back-to-back).
        grant_o = (next_o != IDLE) && ((state_i == IDLE) || mem_resp_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single memory port.
// Memory command outputs are registered at the grant edge and held until
// the edge after mem_resp; responses are forwarded combinationally.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           i_read,
    input  rv32i_word      i_address,
    output rv32i_word      i_rdata,
    output logic           i_resp,

    input  logic           d_read,
    input  logic           d_write,
    input  rv32i_word      d_address,
    input  rv32i_word      d_wdata,
    input  rv32i_mem_wmask d_byte_enable,
    output rv32i_word      d_rdata,
    output logic           d_resp,

    output logic           mem_read,
    output logic           mem_write,
    output rv32i_word      mem_address,
    output rv32i_word      mem_wdata,
    output rv32i_mem_wmask mem_byte_enable,
    input  rv32i_word      mem_rdata,
    input  logic           mem_resp,

    output logic           busy
);

    mem_arb_state_t state_q, state_d;
    mem_cmd_t       cmd_q, cmd_d;
    logic           grant;
    logic           d_req;

    assign d_req = d_read | d_write;

    arb_select #(
        .FAIR (FAIR)
    ) u_arb_select (
        .state_i    (state_q),
        .i_req_i    (i_read),
        .d_req_i    (d_req),
        .mem_resp_i (mem_resp),
        .next_o     (state_d),
        .grant_o    (grant)
    );

    // Build the next memory command: load from the granted port, drop the
    // request after completion, otherwise hold.
    always_comb begin
        cmd_d = cmd_q;
        if ((state_q != IDLE) && mem_resp) begin
            cmd_d.rd = 1'b0;
            cmd_d.wr = 1'b0;
        end
        if (grant) begin
            if (state_d == SERVE_D) begin
                cmd_d.addr  = d_address;
                cmd_d.wdata = d_wdata;
                if (d_write) begin
                    // Write wins if the requester raises both strobes.
                    cmd_d.rd = 1'b0;
                    cmd_d.wr = 1'b1;
                    cmd_d.be = d_byte_enable;
                end else begin
                    cmd_d.rd = 1'b1;
                    cmd_d.wr = 1'b0;
                    cmd_d.be = BE_ALL;
                end
            end else begin
                cmd_d.addr  = i_address;
                cmd_d.wdata = '0;
                cmd_d.rd    = 1'b1;
                cmd_d.wr    = 1'b0;
                cmd_d.be    = BE_ALL;
            end
        end
    end

    // State and command registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    assign mem_read        = cmd_q.rd;
    assign mem_write       = cmd_q.wr;
    assign mem_address     = cmd_q.addr;
    assign mem_wdata       = cmd_q.wdata;
    assign mem_byte_enable = cmd_q.be;

    assign busy    = (state_q != IDLE);
    assign i_resp  = (state_q == SERVE_I) && mem_resp;
    assign d_resp  = (state_q == SERVE_D) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (FAIR=0 at index 0, FAIR=1 at
// index 1) share one stimulus stream and are checked every cycle against a
// transaction-owner model, plus directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read, d_write;
    logic [31:0] d_address, d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic [31:0] i_rdata_o [2];
    logic [31:0] d_rdata_o [2];
    logic [31:0] mem_address_o [2];
    logic [31:0] mem_wdata_o [2];
    logic [3:0]  mem_be_o [2];
    logic        i_resp_o [2];
    logic        d_resp_o [2];
    logic        mem_read_o [2];
    logic        mem_write_o [2];
    logic        busy_o [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.FAIR(g == 1)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .i_read          (i_read),
            .i_address       (i_address),
            .i_rdata         (i_rdata_o[g]),
            .i_resp          (i_resp_o[g]),
            .d_read          (d_read),
            .d_write         (d_write),
            .d_address       (d_address),
            .d_wdata         (d_wdata),
            .d_byte_enable   (d_byte_enable),
            .d_rdata         (d_rdata_o[g]),
            .d_resp          (d_resp_o[g]),
            .mem_read        (mem_read_o[g]),
            .mem_write       (mem_write_o[g]),
            .mem_address     (mem_address_o[g]),
            .mem_wdata       (mem_wdata_o[g]),
            .mem_byte_enable (mem_be_o[g]),
            .mem_rdata       (mem_rdata),
            .mem_resp        (mem_resp),
            .busy            (busy_o[g])
        );
    end

    // Model: who owns the memory (0 none, 1 I, 2 D) and the command held.
    int          m_own [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_be [2];
    logic        m_rd [2];
    logic        m_wr [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_addr[k] = '0; m_wd[k] = '0;
            m_be[k] = '0; m_rd[k] = 1'b0; m_wr[k] = 1'b0;
        end
    endtask

    // Who gets the bus next, given current owner (called only when the bus frees).
    function automatic int pick(int k, int own);
        bit dq = d_read | d_write;
        if (own == 2) begin
            if (k == 1 && i_read) return 1;
            return dq ? 2 : 0;
        end
        if (dq) return 2;
        return i_read ? 1 : 0;
    endfunction

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            if (m_own[k] == 0 || mem_resp) begin
                int nw = pick(k, m_own[k]);
                m_own[k] = nw;
                if (nw == 0) begin
                    m_rd[k] = 1'b0; m_wr[k] = 1'b0;
                end else if (nw == 1) begin
                    m_addr[k] = i_address; m_wd[k] = '0; m_be[k] = 4'hF;
                    m_rd[k] = 1'b1; m_wr[k] = 1'b0;
                end else begin
                    m_addr[k] = d_address; m_wd[k] = d_wdata;
                    m_wr[k] = d_write; m_rd[k] = !d_write;
                    m_be[k] = d_write ? d_byte_enable : 4'hF;
                end
            end
        end
    endtask

    task automatic cmp_cycle();
        for (int k = 0; k < 2; k++) begin
            logic [136:0] e, a;
            logic ir, dr;
            ir = (m_own[k] == 1) && mem_resp;
            dr = (m_own[k] == 2) && mem_resp;
            e = {(m_own[k] != 0), m_rd[k], m_wr[k], m_addr[k], m_wd[k], m_be[k],
                 ir, (ir ? mem_rdata : 32'h0), dr, (dr ? mem_rdata : 32'h0)};
            a = {busy_o[k], mem_read_o[k], mem_write_o[k], mem_address_o[k],
                 mem_wdata_o[k], mem_be_o[k], i_resp_o[k], i_rdata_o[k],
                 d_resp_o[k], d_rdata_o[k]};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cyc_dut%0d t=%0t got=%h exp=%h", k, $time, a, e);
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // Finish the current cycle: compare at negedge, advance model, land at posedge+1.
    task automatic step();
        @(negedge clk);
        cmp_cycle();
        if (rst) model_advance();
        @(posedge clk);
        #1;
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        while ((m_own[0] != 0 || m_own[1] != 0) && n < 20) begin
            mem_resp = 1'b1;
            step();
            n++;
        end
        lit("drain_busy0", 32'(busy_o[0]), 32'd0);
        lit("drain_busy1", 32'(busy_o[1]), 32'd0);
    endtask

    task automatic new_d();
        d_write       = 1'($urandom_range(0, 1));
        d_read        = d_write ? 1'($urandom_range(0, 1)) : 1'b1;
        d_address     = $urandom;
        d_wdata       = $urandom;
        d_byte_enable = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst = 1'b0; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        d_byte_enable = '0; mem_rdata = '0; mem_resp = 1'b0;
        model_reset();
        #2;
        lit("rst_busy", 32'(busy_o[1]), 32'd0);
        lit("rst_mem_read", 32'(mem_read_o[1]), 32'd0);
        lit("rst_mem_write", 32'(mem_write_o[0]), 32'd0);
        lit("rst_mem_addr", mem_address_o[1], 32'd0);
        @(posedge clk); #1;
        step();
        rst = 1'b1;
        step();

        // Single I fetch, response after three wait cycles.
        i_read = 1'b1; i_address = 32'h60;
        step();
        lit("i_mem_read_c1", 32'(mem_read_o[1]), 32'd1);
        lit("i_mem_addr_c1", mem_address_o[1], 32'h60);
        step(); step(); step();
        mem_rdata = 32'h13; mem_resp = 1'b1; #1;
        lit("i_resp_c4", 32'(i_resp_o[1]), 32'd1);
        lit("i_rdata_c4", i_rdata_o[1], 32'h13);
        lit("d_resp_c4", 32'(d_resp_o[1]), 32'd0);
        i_read = 1'b0;
        step();
        lit("busy_c5", 32'(busy_o[1]), 32'd0);
        lit("mem_read_c5", 32'(mem_read_o[1]), 32'd0);

        // mem_resp while idle is ignored.
        mem_resp = 1'b1; #1;
        lit("idle_i_resp", 32'(i_resp_o[1]), 32'd0);
        lit("idle_d_resp", 32'(d_resp_o[0]), 32'd0);
        step();
        lit("idle_busy", 32'(busy_o[0]), 32'd0);

        // Both pending, FAIR=1: D first, then I back-to-back.
        i_read = 1'b1; i_address = 32'h100; d_read = 1'b1; d_address = 32'h2000;
        step();
        lit("fair_d_addr", mem_address_o[1], 32'h2000);
        lit("fair_d_read", 32'(mem_read_o[1]), 32'd1);
        mem_resp = 1'b1; #1;
        lit("fair_d_resp", 32'(d_resp_o[1]), 32'd1);
        lit("fair_i_noresp", 32'(i_resp_o[1]), 32'd0);
        d_read = 1'b0;
        step();
        lit("fair_i_addr", mem_address_o[1], 32'h100);
        lit("fair_i_read_kept", 32'(mem_read_o[1]), 32'd1);
        mem_resp = 1'b1; #1;
        lit("fair_i_resp", 32'(i_resp_o[1]), 32'd1);
        i_read = 1'b0;
        step();
        drain();

        // Both pending, FAIR=0, D re-requests on its response: D again.
        i_read = 1'b1; i_address = 32'h100; d_read = 1'b1; d_address = 32'h2000;
        step();
        lit("nf_d_addr", mem_address_o[0], 32'h2000);
        mem_resp = 1'b1; #1;
        lit("nf_d_resp", 32'(d_resp_o[0]), 32'd1);
        d_address = 32'h2004;
        step();
        lit("nf_d_again_addr", mem_address_o[0], 32'h2004);
        lit("nf_d_again_read", 32'(mem_read_o[0]), 32'd1);
        mem_resp = 1'b1; #1;
        lit("nf_i_waits", 32'(i_resp_o[0]), 32'd0);
        lit("nf_d_resp2", 32'(d_resp_o[0]), 32'd1);
        drain();

        // Masked write, command stable until response.
        d_write = 1'b1; d_address = 32'h3002; d_wdata = 32'hAABB; d_byte_enable = 4'b1100;
        step();
        lit("wr_mem_write", 32'(mem_write_o[1]), 32'd1);
        lit("wr_mem_read", 32'(mem_read_o[1]), 32'd0);
        lit("wr_be", 32'(mem_be_o[1]), 32'hC);
        step();
        lit("wr_addr_hold", mem_address_o[1], 32'h3002);
        lit("wr_wdata_hold", mem_wdata_o[1], 32'hAABB);
        step();
        mem_resp = 1'b1; #1;
        lit("wr_d_resp", 32'(d_resp_o[1]), 32'd1);
        d_write = 1'b0;
        step();
        lit("wr_d_resp_pulse", 32'(d_resp_o[1]), 32'd0);
        lit("wr_mem_write_off", 32'(mem_write_o[1]), 32'd0);

        // Reset mid-transaction, then a normal I grant.
        d_read = 1'b1; d_address = 32'h4000;
        step();
        lit("rst_pre_read", 32'(mem_read_o[1]), 32'd1);
        #2; rst = 1'b0; #1;
        lit("rst_mid_read", 32'(mem_read_o[1]), 32'd0);
        lit("rst_mid_busy", 32'(busy_o[1]), 32'd0);
        lit("rst_mid_addr", mem_address_o[1], 32'd0);
        lit("rst_mid_d_resp", 32'(d_resp_o[1]), 32'd0);
        model_reset();
        d_read = 1'b0;
        step();
        rst = 1'b1; i_read = 1'b1; i_address = 32'h80;
        step();
        lit("post_rst_read", 32'(mem_read_o[1]), 32'd1);
        lit("post_rst_addr", mem_address_o[1], 32'h80);
        drain();

        // Random traffic; requesters react to the FAIR=1 instance's responses.
        for (int c = 0; c < 2000; c++) begin
            mem_resp = ($urandom_range(0, 3) == 0);
            #1;
            if (i_read && i_resp_o[1]) begin
                if ($urandom_range(0, 1) == 0) i_read = 1'b0;
                else i_address = $urandom;
            end else if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1'b1; i_address = $urandom;
            end
            if ((d_read || d_write) && d_resp_o[1]) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_read = 1'b0; d_write = 1'b0;
                end else new_d();
            end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
                new_d();
            end
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0; #1;
                model_reset();
                step();
                rst = 1'b1;
            end
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
